// File: rtl/soric_pkg.sv
// soric_pkg: shared state encoding, timeout error word and defaults for the slave port arbiter
package soric_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after i_last with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);
  logic w_found;
  int   w_j;
  always_comb begin
    o_onehot = '0;
    o_idx = '0;
    w_found = 1'b0;
    w_j = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(i_last) + k) % N;
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: round-robin sharing of one slave port among masters, one outstanding transaction, response timeout
module slave_port_arbiter
  import soric_pkg::*;
#(
  parameter int MASTERS    = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTERS-1:0]                master_data_req_i,
  input  logic [MASTERS*ADDR_WIDTH-1:0]     master_data_addr_i,
  input  logic [MASTERS-1:0]                master_data_we_i,
  input  logic [MASTERS*(DATA_WIDTH/8)-1:0] master_data_be_i,
  input  logic [MASTERS*DATA_WIDTH-1:0]     master_data_wdata_i,
  output logic [MASTERS-1:0]                master_data_gnt_o,
  output logic [MASTERS-1:0]                master_data_rvalid_o,
  output logic [MASTERS*DATA_WIDTH-1:0]     master_data_rdata_o,
  output logic                              slave_data_req_o,
  output logic [ADDR_WIDTH-1:0]             slave_data_addr_o,
  output logic                              slave_data_we_o,
  output logic [DATA_WIDTH/8-1:0]           slave_data_be_o,
  output logic [DATA_WIDTH-1:0]             slave_data_wdata_o,
  input  logic                              slave_data_gnt_i,
  input  logic                              slave_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             slave_data_rdata_i,
  output logic                              err_o
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IW = $clog2(MASTERS);
  state_t r_state, w_state_nx;
  logic [IW-1:0] r_last, r_owner, w_win;
  logic [7:0] r_tcnt;
  logic [MASTERS-1:0] w_onehot;
  logic w_busy, w_rv, w_timeout, w_req, w_grant;
  rr_pick #(.N(MASTERS), .IW(IW)) u_pick (
    .i_req(master_data_req_i),
    .i_last(r_last),
    .o_onehot(w_onehot),
    .o_idx(w_win)
  );
  // Reset gates every output so nothing leaks while reset is held.
  assign w_busy = !reset && r_state == BUSY;
  assign w_rv = w_busy && slave_data_rvalid_i;
  assign w_timeout = w_busy && !slave_data_rvalid_i && r_tcnt == 8'(TIMEOUT - 1);
  assign w_req = !reset && (r_state == IDLE || w_rv) && |master_data_req_i;
  assign w_grant = w_req && slave_data_gnt_i;
  assign slave_data_req_o = w_req;
  assign master_data_gnt_o = w_grant ? w_onehot : '0;
  assign err_o = w_timeout;
  always_comb begin
    slave_data_addr_o = '0;
    slave_data_we_o = 1'b0;
    slave_data_be_o = '0;
    slave_data_wdata_o = '0;
    master_data_rvalid_o = '0;
    master_data_rdata_o = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (w_req && w_onehot[m]) begin
        slave_data_addr_o = master_data_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        slave_data_we_o = master_data_we_i[m];
        slave_data_be_o = master_data_be_i[m*BE_W +: BE_W];
        slave_data_wdata_o = master_data_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_busy && r_owner == IW'(m)) begin
        master_data_rvalid_o[m] = slave_data_rvalid_i || w_timeout;
        master_data_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = w_timeout ? DATA_WIDTH'(ERR_WORD) : slave_data_rdata_i;
      end
    end
  end
  // A new grant in the response cycle keeps the port busy with zero bubble.
  always_comb begin
    w_state_nx = r_state;
    if (w_grant) w_state_nx = BUSY;
    else if (w_rv || w_timeout) w_state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= IW'(MASTERS - 1);
      r_owner <= '0;
      r_tcnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_grant) begin
        r_owner <= w_win;
        r_last <= w_win;
        r_tcnt <= '0;
      end else if (w_busy) r_tcnt <= r_tcnt + 8'd1;
    end
  end
endmodule

// File: doc/slave_port_arbiter.md
SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

Interface
REQ-001 Parameter MASTERS, default 4, number of requesters (2..8).
REQ-002 Parameter ADDR_WIDTH, default 11, slave word address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width; byte-enable width BE_W = DATA_WIDTH/8.
REQ-004 Parameter TIMEOUT, default 16, max cycles from grant to slave rvalid (2..255).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 master_data_req_i  in  MASTERS  per-master request, held until granted.
REQ-008 master_data_addr_i  in  MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 master_data_we_i  in  MASTERS  write enable per master.
REQ-010 master_data_be_i  in  MASTERS*BE_W  packed byte enables.
REQ-011 master_data_wdata_i  in  MASTERS*DATA_WIDTH  packed write data.
REQ-012 master_data_gnt_o  out  MASTERS  one-hot grant, combinational.
REQ-013 master_data_rvalid_o  out  MASTERS  one-hot response strobe.
REQ-014 master_data_rdata_o  out  MASTERS*DATA_WIDTH  packed read data.
REQ-015 slave_data_req_o / _addr_o / _we_o / _be_o / _wdata_o  out  1/ADDR_WIDTH/1/BE_W/DATA_WIDTH  shared slave request.
REQ-016 slave_data_gnt_i  in  1; slave_data_rvalid_i  in  1; slave_data_rdata_i  in  DATA_WIDTH.
REQ-017 err_o  out  1  one-cycle pulse on response timeout.

Function
REQ-018 States IDLE, BUSY; at most one outstanding transaction.
REQ-019 can_issue = (state==IDLE) | (state==BUSY & slave_data_rvalid_i); timeout cycle is never can_issue.
REQ-020 Round-robin winner: first requesting master searching from (last_grant+1) mod MASTERS upward with wrap.
REQ-021 slave_data_req_o = can_issue & |master_data_req_i; slave addr/we/be/wdata muxed from winner, all zero when slave_data_req_o=0.
REQ-022 master_data_gnt_o[winner] = slave_data_req_o & slave_data_gnt_i; all other bits 0.
REQ-023 On grant: owner<=winner, last_grant<=winner, tcnt<=0, state<=BUSY, same cycle.
REQ-024 Grant without slave_data_gnt_i: no state change, request re-arbitrated next cycle (winner may change only if winner drops req).
REQ-025 BUSY: master_data_rvalid_o[owner]=slave_data_rvalid_i, master_data_rdata_o[owner]=slave_data_rdata_i; other lanes rvalid 0, rdata 0.
REQ-026 BUSY & rvalid & no new grant -> IDLE; BUSY & rvalid & new grant -> stay BUSY with new owner (back-to-back, zero bubble).
REQ-027 BUSY & !rvalid: tcnt increments; at tcnt==TIMEOUT-1 assert master_data_rvalid_o[owner]=1, rdata=32'hDEAD_BEEF (low DATA_WIDTH bits), err_o=1, state<=IDLE.
REQ-028 slave_data_rvalid_i in IDLE ignored (no master rvalid, no error).
REQ-029 rvalid and timeout same cycle: rvalid wins, no err_o.
REQ-030 A master that deasserts req before grant loses nothing; no grant issued to non-requesting master.

Reset
REQ-031 reset: state<=IDLE, last_grant<=MASTERS-1 (master 0 wins first), owner<=0, tcnt<=0.
REQ-032 During reset all outputs 0; reset mid-BUSY drops outstanding transaction, late slave rvalid after reset ignored.

Structure
REQ-033 State encoding, DEADBEEF error word and TIMEOUT default in shared package soric_pkg.
REQ-034 One sub-module rr_pick (combinational round-robin priority picker: req vector + last pointer -> one-hot + index).

Verification
REQ-035 Reset release, masters 0 and 2 req, slave gnt=1 rvalid next cycle -> gnt order 0,2; rvalid to 0 then 2; data correct.
REQ-036 All 4 masters req continuously, back-to-back rvalid -> grants 0,1,2,3,0 on consecutive cycles, no bubble.
REQ-037 slave_data_gnt_i=0 for 3 cycles with master 1 req -> gnt_o=0, slave_data_req_o=1 held, grant on 4th cycle.
REQ-038 Grant to master 3, no rvalid -> 16 cycles later rvalid_o[3]=1, rdata=DEADBEEF, err_o=1 one cycle, state IDLE.
REQ-039 Write from master 1 addr 11'h7FF be 4'b0101 wdata 32'h12345678 -> slave sees identical fields, we=1.
REQ-040 Reset asserted while BUSY, slave rvalid one cycle after release -> no master rvalid, next grant goes to master 0.
